// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage. Holds the PC, issues four pipelined
// byte reads on the shared 8-bit memory port, assembles them little-endian
// and presents the complete instruction to the IF/ID register.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned STALL_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic [STALL_W-1:0] stall_sign,
  input  logic               branch_sign_i,
  input  logic [31:0]        branch_target_i,
  input  logic               mem_gnt_i,
  input  logic [7:0]         mem_data_i,
  output logic               mem_req_o,
  output logic [31:0]        mem_addr_o,
  output logic [31:0]        if_pc_o,
  output logic [31:0]        if_inst_o,
  output logic               if_valid_o,
  output logic               stallreq_o
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // issuing byte requests
    DRAIN = 2'd1,  // all four issued, last byte still in flight
    READY = 2'd2   // complete instruction held for IF/ID
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic [2:0]  cap_cnt_q, cap_cnt_d;
  logic        pend_q, pend_d;
  logic [1:0]  pend_idx_q, pend_idx_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        valid_q, valid_d;

  logic [3:0]  lane_we;
  logic [31:0] inst_cap;
  logic        issue_fire;
  logic        accept;

  // Per-byte-lane capture: the returning byte lands in the lane named by
  // the index that was recorded when its request was granted.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi]           = pend_q && (pend_idx_q == 2'(gi));
      assign inst_cap[8*gi +: 8]   = lane_we[gi] ? mem_data_i : inst_q[8*gi +: 8];
    end
  endgenerate

  // Only bits 0 and 1 of the stall bus concern this stage.
  generate
    if (STALL_W > 2) begin : g_unused_stall
      logic unused_stall_bits;
      assign unused_stall_bits = ^stall_sign[STALL_W-1:2];
    end
  endgenerate

  // Byte request: only while fetching, running, not held, and bytes remain.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_addr_o = 32'h0;
    if (!rst) begin
      mem_addr_o = pc_q + {29'd0, issue_cnt_q};
      if (rdy && (state_q == FETCH) && !issue_cnt_q[2]) begin
        mem_req_o = !stall_sign[0];
      end
    end
  end

  assign issue_fire = mem_req_o && mem_gnt_i;
  assign accept     = (state_q == READY) && valid_q && !stall_sign[1];
  assign stallreq_o = (state_q != READY);

  assign if_pc_o    = out_pc_q;
  assign if_inst_o  = inst_q;
  assign if_valid_o = valid_q;

  // Next state: branch beats capture and acceptance; rdy=0 freezes everything.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    pend_d      = pend_q;
    pend_idx_d  = pend_idx_q;
    inst_d      = inst_q;
    out_pc_d    = out_pc_q;
    valid_d     = valid_q;

    if (rdy) begin
      if (branch_sign_i) begin
        // Redirect; any byte still in flight is dropped by clearing pend.
        pc_d        = branch_target_i;
        issue_cnt_d = 3'd0;
        cap_cnt_d   = 3'd0;
        pend_d      = 1'b0;
        valid_d     = 1'b0;
        state_d     = FETCH;
      end else begin
        pend_d = 1'b0;
        inst_d = inst_cap;
        if (pend_q) begin
          cap_cnt_d = cap_cnt_q + 3'd1;
          if (pend_idx_q == 2'd3) begin
            state_d  = READY;
            valid_d  = 1'b1;
            out_pc_d = pc_q;
          end
        end

        if (issue_fire) begin
          pend_d      = 1'b1;
          pend_idx_d  = issue_cnt_q[1:0];
          issue_cnt_d = issue_cnt_q + 3'd1;
          if (issue_cnt_q == 3'd3) begin
            state_d = DRAIN;
          end
        end

        if (accept) begin
          pc_d        = pc_q + 32'd4;
          issue_cnt_d = 3'd0;
          cap_cnt_d   = 3'd0;
          valid_d     = 1'b0;
          state_d     = FETCH;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      issue_cnt_q <= 3'd0;
      cap_cnt_q   <= 3'd0;
      pend_q      <= 1'b0;
      pend_idx_q  <= 2'd0;
      inst_q      <= 32'h0;
      out_pc_q    <= 32'h0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      inst_q      <= inst_d;
      out_pc_q    <= out_pc_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch with a transaction-level
// model (PC, granted/arrived byte counts, memory image) checked every cycle.
module tb_inst_fetch;

  typedef logic [31:0] q32_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [5:0]  stall_sign;
  logic        branch_sign_i;
  logic [31:0] branch_target_i;
  logic        mem_gnt_i;
  logic [7:0]  mem_data_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;
  logic        stallreq_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] addr_log[$];

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .stall_sign      (stall_sign),
    .branch_sign_i   (branch_sign_i),
    .branch_target_i (branch_target_i),
    .mem_gnt_i       (mem_gnt_i),
    .mem_data_i      (mem_data_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .if_valid_o      (if_valid_o),
    .stallreq_o      (stallreq_o)
  );

  // Memory image: addresses 0..3 hold an addi x0,x0,0 (0x00000013).
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (a == 32'd0) return 8'h13;
    if (a < 32'd4) return 8'h00;
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] p);
    return {mem_byte(p + 32'd3), mem_byte(p + 32'd2), mem_byte(p + 32'd1), mem_byte(p)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: log the request, then play memctrl (byte one cycle after a
  // grant; bus frozen while rdy=0; junk otherwise).
  task automatic step();
    logic        sreq, sg, sr;
    logic [31:0] saddr;
    @(negedge clk);
    sreq  = mem_req_o;
    saddr = mem_addr_o;
    sg    = mem_gnt_i;
    sr    = rdy;
    if (sreq && sr) addr_log.push_back(saddr);
    @(posedge clk);
    #1;
    if (sr) mem_data_i = (sreq && sg) ? mem_byte(saddr) : 8'hEE;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!if_valid_o && n < 30) begin
      step();
      n++;
    end
    chk({name, "_valid"}, {31'd0, if_valid_o}, 32'd1);
    $display("fetch %s: pc=%h inst=%h cycles=%0d", name, if_pc_o, if_inst_o, n);
  endtask

  task automatic chk_log(input string name, input q32_t e);
    chk({name, "_len"}, addr_log.size(), e.size());
    for (int i = 0; i < e.size() && i < addr_log.size(); i++) begin
      chk(name, addr_log[i], e[i]);
    end
  endtask

  // Behavioural model and per-cycle compare.
  logic [31:0] m_pc, m_inst, m_opc;
  int          m_gr, m_ar;
  logic        m_inf, m_val;
  logic        started = 1'b0;

  always @(negedge clk) begin : model_cmp
    logic        exp_req, g;
    logic [31:0] n_pc, n_inst, n_opc;
    int          n_gr, n_ar;
    logic        n_inf, n_val;
    if (rst) begin
      chk("rst_req", {31'd0, mem_req_o}, 32'd0);
      chk("rst_addr", mem_addr_o, 32'd0);
      m_pc    <= 32'h0;
      m_gr    <= 0;
      m_ar    <= 0;
      m_inf   <= 1'b0;
      m_val   <= 1'b0;
      m_inst  <= 32'h0;
      m_opc   <= 32'h0;
      started <= 1'b1;
    end else if (started) begin
      exp_req = rdy && !m_val && (m_gr < 4) && !stall_sign[0];
      chk("m_req", {31'd0, mem_req_o}, {31'd0, exp_req});
      if (exp_req) chk("m_addr", mem_addr_o, m_pc + 32'(m_gr));
      chk("m_valid", {31'd0, if_valid_o}, {31'd0, m_val});
      chk("m_stallreq", {31'd0, stallreq_o}, {31'd0, !m_val});
      if (m_val) begin
        chk("m_inst", if_inst_o, m_inst);
        chk("m_pc", if_pc_o, m_opc);
      end
      n_pc = m_pc; n_inst = m_inst; n_opc = m_opc;
      n_gr = m_gr; n_ar = m_ar; n_inf = m_inf; n_val = m_val;
      if (rdy) begin
        if (branch_sign_i) begin
          n_pc = branch_target_i; n_gr = 0; n_ar = 0; n_inf = 1'b0; n_val = 1'b0;
        end else begin
          g = exp_req && mem_gnt_i;
          if (m_inf) begin
            n_ar = m_ar + 1;
            if (n_ar == 4) begin
              n_val  = 1'b1;
              n_inst = mem_word(m_pc);
              n_opc  = m_pc;
            end
          end else if (m_val && !stall_sign[1]) begin
            n_pc = m_pc + 32'd4; n_gr = 0; n_ar = 0; n_val = 1'b0;
          end
          if (g) n_gr = n_gr + 1;
          n_inf = g;
        end
      end
      m_pc <= n_pc; m_inst <= n_inst; m_opc <= n_opc;
      m_gr <= n_gr; m_ar <= n_ar; m_inf <= n_inf; m_val <= n_val;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          n;
    q32_t        e;
    logic [47:0] pg, ps0, ps1, pr, pb;

    rst = 1'b1; rdy = 1'b1; stall_sign = 6'd0; branch_sign_i = 1'b0;
    branch_target_i = 32'h0; mem_gnt_i = 1'b1; mem_data_i = 8'h00;

    // T1: reset, then first fetch from address 0.
    #1;
    chk("t1_rst_req", {31'd0, mem_req_o}, 32'd0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("t1_valid0", {31'd0, if_valid_o}, 32'd0);
    chk("t1_inst0", if_inst_o, 32'h0);
    chk("t1_pc0", if_pc_o, 32'h0);
    chk("t1_stallreq0", {31'd0, stallreq_o}, 32'd1);
    addr_log.delete();
    wait_valid("t1", n);
    chk("t1_lat", n, 32'd5);
    e = '{32'h0, 32'h1, 32'h2, 32'h3};
    chk_log("t1_addr", e);
    chk("t1_inst", if_inst_o, 32'h0000_0013);
    chk("t1_pc", if_pc_o, 32'h0);
    chk("t1_stallreq", {31'd0, stallreq_o}, 32'd0);

    // T2: IF/ID stalled for 3 cycles holds the instruction.
    stall_sign = 6'b000010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_valid", {31'd0, if_valid_o}, 32'd1);
      chk("t2_inst", if_inst_o, 32'h0000_0013);
      chk("t2_req", {31'd0, mem_req_o}, 32'd0);
      step();
    end
    stall_sign = 6'd0;
    step();
    #1;
    chk("t2_req_after", {31'd0, mem_req_o}, 32'd1);
    chk("t2_addr_after", mem_addr_o, 32'h4);

    // T3: grant withheld for two cycles during the byte-2 request.
    addr_log.delete();
    n = 0;
    while (!if_valid_o && n < 30) begin
      mem_gnt_i = (n == 2 || n == 3) ? 1'b0 : 1'b1;
      step();
      n++;
    end
    mem_gnt_i = 1'b1;
    chk("t3_lat", n, 32'd7);
    e = '{32'h4, 32'h5, 32'h6, 32'h6, 32'h6, 32'h7};
    chk_log("t3_addr", e);
    chk("t3_inst", if_inst_o, 32'hA2A3_A0A1);
    chk("t3_pc", if_pc_o, 32'h4);
    $display("fetch t3: pc=%h inst=%h cycles=%0d", if_pc_o, if_inst_o, n);

    // T4: branch while byte 1 is in flight.
    step();
    step(); step();
    branch_sign_i = 1'b1; branch_target_i = 32'h100;
    step();
    branch_sign_i = 1'b0;
    addr_log.delete();
    wait_valid("t4", n);
    chk("t4_lat", n, 32'd5);
    e = '{32'h100, 32'h101, 32'h102, 32'h103};
    chk_log("t4_addr", e);
    chk("t4_inst", if_inst_o, 32'hA7A6_A5A4);
    chk("t4_pc", if_pc_o, 32'h100);

    // T5: rdy low for 4 cycles mid-fetch with the pending byte held.
    step();
    addr_log.delete();
    step(); step();
    rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t5_req", {31'd0, mem_req_o}, 32'd0);
      chk("t5_valid", {31'd0, if_valid_o}, 32'd0);
      step();
    end
    rdy = 1'b1;
    wait_valid("t5", n);
    chk("t5_lat", n, 32'd3);
    e = '{32'h104, 32'h105, 32'h106, 32'h107};
    chk_log("t5_addr", e);
    chk("t5_inst", if_inst_o, 32'hA3A2_A1A0);
    chk("t5_pc", if_pc_o, 32'h104);

    // T6: acceptance and branch in the same cycle; branch wins.
    branch_sign_i = 1'b1; branch_target_i = 32'h200;
    step();
    branch_sign_i = 1'b0;
    #1;
    chk("t6_req", {31'd0, mem_req_o}, 32'd1);
    chk("t6_addr", mem_addr_o, 32'h200);
    wait_valid("t6", n);
    chk("t6_lat", n, 32'd5);
    chk("t6_inst", if_inst_o, 32'hA4A5_A6A7);
    chk("t6_pc", if_pc_o, 32'h200);

    // T7a: branch during IF/ID stall to an unaligned, wrapping PC, with issue hold.
    stall_sign = 6'b000010;
    branch_sign_i = 1'b1; branch_target_i = 32'hFFFF_FFFE;
    step();
    branch_sign_i = 1'b0; stall_sign = 6'd0;
    addr_log.delete();
    n = 0;
    while (!if_valid_o && n < 30) begin
      stall_sign[0] = (n == 1 || n == 2);
      step();
      n++;
    end
    stall_sign = 6'd0;
    chk("t7a_lat", n, 32'd7);
    e = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    chk_log("t7a_addr", e);
    chk("t7a_inst", if_inst_o, 32'h0013_A5A4);
    chk("t7a_pc", if_pc_o, 32'hFFFF_FFFE);
    $display("fetch t7a: pc=%h inst=%h cycles=%0d", if_pc_o, if_inst_o, n);

    // T7b: branch while the last byte is in flight.
    step();
    step(); step(); step(); step();
    branch_sign_i = 1'b1; branch_target_i = 32'h300;
    step();
    branch_sign_i = 1'b0;
    #1;
    chk("t7b_valid", {31'd0, if_valid_o}, 32'd0);
    chk("t7b_addr", mem_addr_o, 32'h300);
    wait_valid("t7b", n);
    chk("t7b_inst", if_inst_o, 32'hA5A4_A7A6);
    chk("t7b_pc", if_pc_o, 32'h300);

    // T7c: reset mid-fetch discards everything.
    step(); step();
    rst = 1'b1;
    step();
    #1;
    chk("t7c_valid", {31'd0, if_valid_o}, 32'd0);
    chk("t7c_inst", if_inst_o, 32'h0);
    chk("t7c_pc", if_pc_o, 32'h0);
    chk("t7c_stallreq", {31'd0, stallreq_o}, 32'd1);
    rst = 1'b0;
    wait_valid("t7c", n);
    chk("t7c_lat", n, 32'd5);
    chk("t7c_inst2", if_inst_o, 32'h0000_0013);

    // T8: mixed directed control pattern, checked by the model.
    pg  = 48'hFBDF_77EE_FDBF;
    ps0 = 48'h0410_2008_0100;
    ps1 = 48'h0C00_3000_0600;
    pr  = 48'hFFEF_FF3F_FFFB;
    pb  = 48'h0040_0002_0000;
    for (int i = 0; i < 48; i++) begin
      mem_gnt_i       = pg[i];
      stall_sign[0]   = ps0[i];
      stall_sign[1]   = ps1[i];
      rdy             = pr[i];
      branch_sign_i   = pb[i];
      branch_target_i = 32'h500 + 32'(i);
      step();
    end
    mem_gnt_i = 1'b1; stall_sign = 6'd0; rdy = 1'b1; branch_sign_i = 1'b0;
    wait_valid("t8", n);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- IF stage of the 5-stage RISC-V core; sits directly upstream of the IF/ID pipeline register.
- Owns the PC and assembles each 32-bit instruction from four byte reads on the shared 8-bit memory port, pipelining byte requests.
- Presents pc/inst/valid to IF/ID, raises a stall request to ctrl while an instruction is incomplete, and redirects on branch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- STALL_W, 6, width of stall_sign bus

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- rdy  in  1  global run enable; 0 freezes all state
- stall_sign  in  STALL_W  from ctrl; bit0 = hold IF issue, bit1 = IF/ID stalled
- branch_sign_i  in  1  redirect request from EX
- branch_target_i  in  32  redirect PC
- mem_gnt_i  in  1  memctrl accepted this cycle's byte request (MEM stage has priority)
- mem_data_i  in  8  byte returned one cycle after a granted request
- mem_req_o  out  1  byte read request
- mem_addr_o  out  32  byte address
- if_pc_o  out  32  PC of presented instruction
- if_inst_o  out  32  assembled instruction, little-endian
- if_valid_o  out  1  if_inst_o/if_pc_o complete and not yet accepted
- stallreq_o  out  1  to ctrl; 1 while no complete instruction is held

Behaviour:
- Reset (rst=1 at posedge, overrides rdy): pc=RESET_PC; issue_cnt=0; cap_cnt=0; pend=0; state=FETCH; if_inst_o=0; if_pc_o=0; if_valid_o=0; mem_req_o=0; mem_addr_o=0; stallreq_o=1. Reset mid-fetch discards all captured bytes.
- rdy=0: no register changes, mem_req_o=0. Memctrl is also frozen, so mem_data_i stays stable and any pending byte is captured after rdy returns.
- States: FETCH (issuing bytes), DRAIN (all 4 issued, last byte outstanding), READY (instruction held).
- FETCH: mem_req_o=!stall_sign[0]; mem_addr_o=pc+issue_cnt (32-bit wrap). On mem_gnt_i&&mem_req_o: pend<=1, pend_idx<=issue_cnt, issue_cnt++. Otherwise pend<=0 and the same address is reissued next cycle.
- After issue_cnt reaches 4, go to DRAIN.
- Capture, any state, when pend=1: byte pend_idx of if_inst_o <= mem_data_i (idx0 -> [7:0], ... idx3 -> [31:24]); cap_cnt++.
- Capture of idx3 completes the instruction: state<=READY, if_valid_o<=1, if_pc_o<=pc. Best case is 5 cycles from first request to if_valid_o.
- stallreq_o = (state!=READY), combinational from state.
- READY: mem_req_o=0. Acceptance = rdy && !stall_sign[1] && if_valid_o.
- On acceptance: pc<=pc+4, issue/cap counters cleared, if_valid_o<=0, state<=FETCH; first request of the next fetch goes out the following cycle.
- While stall_sign[1]=1: if_valid_o, if_inst_o and if_pc_o are held unchanged.
- Branch (branch_sign_i=1, rdy=1), any state, priority over acceptance and capture:
  - pc<=branch_target_i; counters cleared; pend<=0; if_valid_o<=0; state<=FETCH.
  - The byte arriving next cycle for the aborted request is discarded.
  - No mem_req_o in the branch cycle's successor is suppressed: new fetch starts the next cycle.
- stall_sign[0]=1 in FETCH: no new requests; pending capture still completes. Counters are not advanced.
- mem_gnt_i low while mem_req_o high: request retried; no byte index skipped or duplicated.
- pc is not required to be 4-aligned; each byte address is computed as pc+idx.

Test Plan:
- Reset then mem returns 13,00,00,00 for addr 0..3 with gnt always 1 -> mem_addr_o 0,1,2,3 on cycles 1-4; if_valid_o=1 cycle 5 with if_inst_o=32'h0000_0013, if_pc_o=0; stallreq_o 1->0.
- Hold stall_sign[1]=1 for 3 cycles after valid -> outputs unchanged, no mem_req_o; release -> next mem_addr_o=4 one cycle later.
- Drop mem_gnt_i during the byte-2 request for 2 cycles -> mem_addr_o=2 repeated 3 cycles; final inst bytes correct; valid delayed by 2 cycles.
- branch_sign_i=1, target 32'h100 while byte1 pending -> stale byte ignored; next requests 100,101,102,103; if_pc_o=32'h100.
- rdy=0 for 4 cycles mid-fetch with mem_data_i held -> no state change, mem_req_o=0; fetch resumes and produces the same instruction.
- Simultaneous acceptance and branch in READY -> pc=branch target, not pc+4.
